// File: rtl/alien_fire_sched.sv
// Frame-rate bomb scheduler: round-robin pick of an alive alien into the lowest free bomb slot,
// plus per-frame bomb motion with retirement on hit or at the bottom of the screen.
module alien_fire_sched #(
   parameter int unsigned N_ALIENS    = 8,
   parameter int unsigned N_BOMBS     = 2,
   parameter int unsigned FIRE_PERIOD = 32,
   parameter int unsigned BOMB_SPEED  = 4,
   parameter int unsigned VLIMIT      = 720,
   parameter bit          RANDOMIZE   = 1'b1,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic                      pixel_clk,
   input  logic                      rst,
   input  logic                      fsync,
   input  logic                      enable,
   input  logic [N_ALIENS-1:0]       alien_alive,
   input  logic [N_ALIENS-1:0][11:0] alien_lhpos,
   input  logic [N_ALIENS-1:0][11:0] alien_rhpos,
   input  logic [N_ALIENS-1:0][11:0] alien_bvpos,
   input  logic [N_BOMBS-1:0]        bomb_hit,
   output logic [N_ALIENS-1:0]       fire_grant,
   output logic [N_BOMBS-1:0]        bomb_valid,
   output logic [N_BOMBS-1:0][11:0]  bomb_x,
   output logic [N_BOMBS-1:0][11:0]  bomb_y,
   output logic [15:0]               launch_count
);

   localparam int unsigned PtrW  = $clog2(N_ALIENS);
   localparam int unsigned SlotW = (N_BOMBS > 1) ? $clog2(N_BOMBS) : 1;
   localparam int unsigned CdW   = $clog2(FIRE_PERIOD + 1);
   localparam logic [CdW-1:0]    CdReload = CdW'(FIRE_PERIOD - 1);
   localparam logic signed [11:0] YLimit  = 12'(VLIMIT);
   localparam logic [11:0]       YStep    = 12'(BOMB_SPEED);

   logic [7:0]               lfsr_q, lfsr_d;
   logic [CdW-1:0]           cd_q, cd_d;
   logic [PtrW-1:0]          rr_q, rr_d;
   logic [N_ALIENS-1:0]      grant_q, grant_d;
   logic [N_BOMBS-1:0]       valid_q, valid_d;
   logic [N_BOMBS-1:0][11:0] x_q, x_d, y_q, y_d;
   logic [15:0]              cnt_q, cnt_d;

   logic             free_found, sel_found, launch;
   logic [SlotW-1:0] free_slot;
   logic [PtrW-1:0]  sel;
   logic [12:0]      x_sum;
   logic [11:0]      y_new;
   int               start_idx, idx;

   // Lowest free slot, judged on registered valid so a slot freed this edge waits a frame.
   always_comb begin
      free_found = 1'b0;
      free_slot  = '0;
      for (int s = 0; s < int'(N_BOMBS); s++) begin
         if (!valid_q[s] && !free_found) begin
            free_found = 1'b1;
            free_slot  = SlotW'(s);
         end
      end
   end

   always_comb begin
      sel_found = 1'b0;
      sel       = '0;
      idx       = 0;
      start_idx = (int'(rr_q) + (RANDOMIZE ? int'(lfsr_q[1:0]) : 0)) % int'(N_ALIENS);
      for (int k = 0; k < int'(N_ALIENS); k++) begin
         idx = (start_idx + k) % int'(N_ALIENS);
         if (alien_alive[PtrW'(idx)] && !sel_found) begin
            sel_found = 1'b1;
            sel       = PtrW'(idx);
         end
      end
   end

   // 13-bit sum keeps the carry so the arithmetic halving is exact for signed edges.
   assign x_sum  = {alien_lhpos[sel][11], alien_lhpos[sel]} +
                   {alien_rhpos[sel][11], alien_rhpos[sel]};
   assign launch = fsync && enable && (cd_q == '0) && free_found && sel_found;

   always_comb begin
      lfsr_d  = lfsr_q;
      cd_d    = cd_q;
      rr_d    = rr_q;
      grant_d = '0;
      valid_d = valid_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      y_new   = '0;
      if (fsync) begin
         lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
         if (enable && cd_q != '0) begin
            cd_d = cd_q - 1'b1;
         end
         for (int s = 0; s < int'(N_BOMBS); s++) begin
            if (valid_q[s] && !bomb_hit[s]) begin
               y_new  = y_q[s] + YStep;
               y_d[s] = y_new;
               if ($signed(y_new) >= YLimit) begin
                  valid_d[s] = 1'b0;
               end
            end
         end
         if (launch) begin
            valid_d[free_slot] = 1'b1;
            x_d[free_slot]     = x_sum[12:1];
            y_d[free_slot]     = alien_bvpos[sel] + 12'd1;
            rr_d               = PtrW'((int'(sel) + 1) % int'(N_ALIENS));
            cd_d               = CdReload;
            cnt_d              = cnt_q + 16'd1;
            grant_d[sel]       = 1'b1;
         end
      end
      for (int s = 0; s < int'(N_BOMBS); s++) begin
         if (bomb_hit[s] && valid_q[s]) begin
            valid_d[s] = 1'b0;
         end
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         lfsr_q  <= LFSR_SEED;
         cd_q    <= CdReload;
         rr_q    <= '0;
         grant_q <= '0;
         valid_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
      end else begin
         lfsr_q  <= lfsr_d;
         cd_q    <= cd_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fire_grant   = grant_q;
   assign bomb_valid   = valid_q;
   assign bomb_x       = x_q;
   assign bomb_y       = y_q;
   assign launch_count = cnt_q;

endmodule

// File: doc/alien_fire_sched.md
Name: alien_fire_sched

Overview:
- Frame-rate scheduler that decides which alien drops a bomb. It arbitrates a small shared pool of bomb slots among N alien instances.
- Tracks each live bomb's position frame by frame and retires bombs on a hit or at the screen bottom.
- Sits between the alien instances (alive flags, bounding boxes) and the bomb renderer / player collision detector.

Parameters:
- N_ALIENS, 8, number of alien requesters (2..16).
- N_BOMBS, 2, number of concurrent bomb slots (1..4).
- FIRE_PERIOD, 32, frames between launch attempts (>=1).
- BOMB_SPEED, 4, pixels per frame of downward bomb motion.
- VLIMIT, 720, bomb is retired when its y reaches or passes this value.
- RANDOMIZE, 1, 1 = LFSR skew on the round-robin start index; 0 = pure round-robin.
- LFSR_SEED, 8'hA5, LFSR reset value (must be non-zero).

Ports:
- pixel_clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fsync  in  1  one-cycle frame strobe; all scheduling and motion happen on this cycle.
- enable  in  1  game running; when low, no launches occur.
- alien_alive  in  N_ALIENS  alive flag per alien.
- alien_lhpos  in  N_ALIENS x 12 signed  left edge per alien.
- alien_rhpos  in  N_ALIENS x 12 signed  right edge per alien.
- alien_bvpos  in  N_ALIENS x 12 signed  bottom edge per alien.
- bomb_hit  in  N_BOMBS  per-slot hit pulse from the collision detector.
- fire_grant  out  N_ALIENS  one-hot, one-cycle pulse naming the launching alien.
- bomb_valid  out  N_BOMBS  slot occupied.
- bomb_x  out  N_BOMBS x 12 signed  bomb horizontal centre.
- bomb_y  out  N_BOMBS x 12 signed  bomb top.
- launch_count  out  16  total launches since reset; wraps modulo 2^16.

Behaviour:
- Reset values:
  - bomb_valid, fire_grant, bomb_x, bomb_y and launch_count are 0.
  - cooldown = FIRE_PERIOD-1; rr_ptr = 0; lfsr = LFSR_SEED.
- Clock enable:
  - State changes only on cycles with fsync=1, except bomb_hit and fire_grant clearing (below).
  - With fsync=0, all state holds.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances once per fsync, regardless of enable.
- Cooldown:
  - On fsync with enable=1 and cooldown>0: decrement.
  - With enable=0: hold.
- Launch condition (evaluated on fsync, all terms true): enable=1, cooldown==0, at least one slot has bomb_valid=0 (registered value), and alien_alive is non-zero.
- Selection:
  - start = (rr_ptr + (RANDOMIZE ? lfsr[1:0] : 0)) mod N_ALIENS.
  - Choose the first alive alien at index >= start, wrapping upward.
- Launch actions (same edge):
  - The lowest-indexed free slot s sets bomb_valid[s]=1.
  - bomb_x[s] = (lhpos+rhpos)>>>1, using a 13-bit intermediate.
  - bomb_y[s] = bvpos+1.
  - rr_ptr = (sel+1) mod N_ALIENS.
  - cooldown = FIRE_PERIOD-1.
  - launch_count increments.
  - fire_grant = one-hot(sel) for exactly one cycle, then returns to 0.
- Blocked launch: if cooldown==0 but no slot is free or no alien is alive, cooldown stays 0 and the launch is retried every subsequent fsync.
- Motion: on fsync, each slot valid before this edge moves y += BOMB_SPEED. If the new y >= VLIMIT, the slot clears (valid=0). A slot launched on this edge does not move until the next fsync.
- Hit:
  - bomb_hit[i]=1 on any cycle clears bomb_valid[i] on that edge.
  - Hit has priority over motion.
  - A hit on an invalid slot is ignored.
  - A slot freed on an fsync edge (by hit or VLIMIT) is not reusable until the next fsync, because free is computed from registered valid.
- bomb_x and bomb_y of an invalid slot hold their last value; the renderer gates on bomb_valid.
- Reset mid-operation: every bomb disappears the next cycle and the schedule restarts from the reset values above.
- Arithmetic: all positions are 12-bit signed; no saturation is required, because retirement at VLIMIT precedes overflow.

Test Plan:
- Reset, RANDOMIZE=0, FIRE_PERIOD=4, all 8 alive, enable=1, 4 fsyncs -> fire_grant=8'h01 one cycle after the 4th fsync; bomb_valid=01; bomb_x=(lh0+rh0)/2; bomb_y=bv0+1; launch_count=1.
- Continue with aliens 1,2 dead -> next grants go to alien 3 then alien 4 (both slots then full); the next attempt blocks with cooldown held at 0 until a slot frees.
- Bomb launched at y=701, BOMB_SPEED=4, VLIMIT=720 -> y=705,709,713,717 on successive fsyncs; valid=0 after the 5th fsync.
- bomb_hit[0] pulse mid-frame -> bomb_valid[0]=0 next cycle; the next eligible fsync reuses slot 0 (lowest free).
- enable=0 for 10 frames -> no grants, cooldown frozen, live bombs keep falling; re-enabling resumes the countdown from the held value.
- All aliens dead -> no grant ever, launch_count constant; rst asserted with 2 live bombs -> all outputs 0 on the next cycle.
